irqctl: RTL and testbench

Parametrised interrupt controller between the board's interrupt sources (timers, serial lines, keyboard, disk, ...) and the CPU `irq` inputs. It replaces fixed source-to-line wiring with synchronisation, per-source edge/level mode, latching, masking and a highest-priority vector register. Software accesses it as an ordinary bus slave through the bus controller, with the same `en`/`wr`/`addr`/`data`/`wt` handshake as the other I/O devices.

---
 rtl/irqctl_pkg.sv | 15 +
 rtl/irqctl_prio.sv | 16 +
 rtl/irqctl.sv | 82 ++++++++
 tb/tb_irqctl.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/irqctl_pkg.sv
// irqctl_pkg: register map, VEC layout and parameter bounds shared by the interrupt controller.
package irqctl_pkg;
  typedef enum logic [1:0] {
    IRQCTL_PEND = 2'd0,
    IRQCTL_MASK = 2'd1,
    IRQCTL_MODE = 2'd2,
    IRQCTL_VEC  = 2'd3
  } irqctl_reg_e;
  localparam int IRQCTL_VEC_VALID = 31;
  localparam int IRQCTL_NUM_MIN = 1;
  localparam int IRQCTL_NUM_MAX = 32;
  function automatic logic [31:0] irqctl_vec(input logic valid, input logic [4:0] idx);
    return valid ? ((32'd1 << IRQCTL_VEC_VALID) | 32'(idx)) : 32'd0;
  endfunction
endpackage

// File: rtl/irqctl_prio.sv
// irqctl_prio: combinational highest-index priority encoder over the active requests.
module irqctl_prio
  import irqctl_pkg::*;
#(
  parameter int NUM_IRQ = 16
) (
  input  logic [NUM_IRQ-1:0] req,
  output logic               valid,
  output logic [4:0]         idx
);
  always_comb begin
    idx = '0;
    for (int i = IRQCTL_NUM_MIN - 1; i < NUM_IRQ; i++) if (req[i]) idx = 5'(i);
  end
  assign valid = |req;
endmodule

// File: rtl/irqctl.sv
// irqctl: interrupt controller with per-source edge/level mode, masking and a priority vector register.
// Define IRQCTL_SYNC_EN to pass every source through a SYNC_STAGES flip-flop synchroniser.
module irqctl
  import irqctl_pkg::*;
#(
  parameter int NUM_IRQ     = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               wr,
  input  logic [3:2]         addr,
  input  logic [31:0]        data_in,
  output logic [31:0]        data_out,
  output logic               wt,
  input  logic [NUM_IRQ-1:0] src,
  output logic [NUM_IRQ-1:0] irq,
  output logic               irq_any
);
`ifdef IRQCTL_SYNC_EN
  localparam bit SYNC_ON = 1'b1;
`else
  localparam bit SYNC_ON = 1'b0;
`endif
  localparam int STAGES = SYNC_ON ? SYNC_STAGES : 0;
  logic [NUM_IRQ-1:0] s, s_d, rise, lat, pend, mask, mode, mode_nx, clr, wd, pm;
  logic [31:0] rdata;
  logic ph, cap, vld, unused_hi;
  logic [4:0] idx;
  if (STAGES > 0) begin : g_sync
    for (genvar i = 0; i < NUM_IRQ; i++) begin : g_bit
      logic [STAGES-1:0] ff;
      always_ff @(posedge clk or posedge reset)
        if (reset) ff <= '0;
        else ff <= {ff[STAGES-2:0], src[i]};
      assign s[i] = ff[STAGES-1];
    end
  end else begin : g_nosync
    assign s = src;
  end
  assign wt = en & ~ph;
  assign cap = en & ~ph;
  assign wd = data_in[NUM_IRQ-1:0];
  assign unused_hi = ^data_in;
  assign clr = (cap & wr & addr == IRQCTL_PEND) ? wd : '0;
  assign mode_nx = (cap & wr & addr == IRQCTL_MODE) ? wd : mode;
  assign rise = s & ~s_d;
  // a rise in the same cycle as a software clear keeps the bit pending
  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_lat
    logic q;
    always_ff @(posedge clk or posedge reset)
      if (reset) q <= 1'b0;
      else q <= mode_nx[i] & ((rise[i] & mode[i]) | (q & ~clr[i]));
    assign lat[i] = q;
  end
  assign pend = lat | (~mode & s);
  assign pm = pend & mask;
  irqctl_prio #(.NUM_IRQ(NUM_IRQ)) u_prio (.req(pm), .valid(vld), .idx(idx));
  assign rdata = addr == IRQCTL_PEND ? IRQCTL_NUM_MAX'(pend)
               : addr == IRQCTL_MASK ? IRQCTL_NUM_MAX'(mask)
               : addr == IRQCTL_MODE ? IRQCTL_NUM_MAX'(mode)
               : irqctl_vec(vld, idx);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ph       <= 1'b0;
      s_d      <= '0;
      mask     <= '0;
      mode     <= '0;
      irq      <= '0;
      irq_any  <= 1'b0;
      data_out <= '0;
    end else begin
      ph      <= en & ~ph;
      s_d     <= s;
      mode    <= mode_nx;
      irq     <= pm;
      irq_any <= |pm;
      if (cap) data_out <= rdata;
      if (cap & wr & addr == IRQCTL_MASK) mask <= wd;
    end
endmodule

// File: tb/tb_irqctl.sv
// tb_irqctl: directed self-checking bench for irqctl (16-source and 5-source instances).
module tb_irqctl;
`ifdef IRQCTL_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif
  logic clk = 1'b0, reset = 1'b1, en = 1'b0, en5 = 1'b0, wr = 1'b0;
  logic [1:0] addr = '0;
  logic [31:0] data_in = '0, data_out, data_out5, q;
  logic wt, wt5, irq_any, irq_any5;
  logic [15:0] src = 16'hFFFF, irq;
  logic [4:0] src5 = '0, irq5;
  int n_chk = 0, n_err = 0;

  irqctl u_dut (
    .clk(clk), .reset(reset), .en(en), .wr(wr), .addr(addr), .data_in(data_in),
    .data_out(data_out), .wt(wt), .src(src), .irq(irq), .irq_any(irq_any)
  );
  irqctl #(.NUM_IRQ(5)) u_dut5 (
    .clk(clk), .reset(reset), .en(en5), .wr(wr), .addr(addr), .data_in(data_in),
    .data_out(data_out5), .wt(wt5), .src(src5), .irq(irq5), .irq_any(irq_any5)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic acc(input bit five, input bit w, input logic [1:0] a, input logic [31:0] d,
                     output logic [31:0] r);
    @(negedge clk);
    wr = w;
    addr = a;
    data_in = d;
    if (five) en5 = 1'b1;
    else en = 1'b1;
    @(negedge clk);
    r = five ? data_out5 : data_out;
    en = 1'b0;
    en5 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_any", 32'(irq_any), 0);
    chk("rst_dout", data_out, 0);
    chk("rst_wt", 32'(wt), 0);
    reset = 1'b0;
    repeat (LAT + 2) @(negedge clk);
    chk("nomask_irq", 32'(irq), 0);
    chk("nomask_any", 32'(irq_any), 0);
    @(negedge clk);
    en = 1'b1; wr = 1'b0; addr = 2'd3;
    #1 chk("wt_first", 32'(wt), 1);
    @(negedge clk);
    chk("wt_done", 32'(wt), 0);
    chk("vec_zero", data_out, 0);
    en = 1'b0;
    acc(0, 1, 2'd1, 32'h0000FFFF, q);
    chk("mask_lat0", 32'(irq), 0);
    @(negedge clk);
    chk("mask_irq", 32'(irq), 32'h0000FFFF);
    chk("mask_any", 32'(irq_any), 1);
    acc(0, 0, 2'd3, 0, q);
    chk("vec_f", q, 32'h8000000F);
    // edge-mode source 8
    src = '0;
    acc(0, 1, 2'd1, 32'h00000100, q);
    acc(0, 1, 2'd2, 32'h00000100, q);
    repeat (LAT + 2) @(negedge clk);
    src = 16'h0100;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      if (k == 1) src = '0;
      chk("edge_lat", 32'(irq[8]), 32'(k == LAT));
    end
    acc(0, 0, 2'd0, 0, q);
    chk("pend_held", q, 32'h00000100);
    chk("edge_any", 32'(irq_any), 1);
    acc(0, 1, 2'd0, 32'h00000100, q);
    chk("clr_lat0", 32'(irq[8]), 1);
    @(negedge clk);
    chk("clr_irq", 32'(irq[8]), 0);
    acc(0, 0, 2'd0, 0, q);
    chk("clr_pend", q, 0);
    // rise coinciding with clear
    @(negedge clk);
    src = 16'h0100;
    repeat (LAT - 2) @(negedge clk);
    en = 1'b1; wr = 1'b1; addr = 2'd0; data_in = 32'h00000100;
    @(negedge clk);
    en = 1'b0;
    src = '0;
    acc(0, 0, 2'd0, 0, q);
    chk("set_wins", q, 32'h00000100);
    acc(0, 1, 2'd2, 0, q);
    acc(0, 0, 2'd0, 0, q);
    chk("mode_clr", q, 0);
    // level sources
    acc(0, 1, 2'd1, 32'h00000013, q);
    src = 16'h0013;
    repeat (LAT + 2) @(negedge clk);
    acc(0, 0, 2'd3, 0, q);
    chk("vec_4", q, 32'h80000004);
    acc(0, 0, 2'd0, 0, q);
    chk("pend_lvl", q, 32'h00000013);
    chk("irq_lvl", 32'(irq), 32'h00000013);
    src = 16'h0003;
    repeat (LAT + 2) @(negedge clk);
    acc(0, 0, 2'd3, 0, q);
    chk("vec_1", q, 32'h80000001);
    acc(0, 1, 2'd3, 32'hFFFFFFFF, q);
    acc(0, 0, 2'd3, 0, q);
    chk("vec_ro", q, 32'h80000001);
    acc(0, 0, 2'd1, 0, q);
    chk("mask_rb", q, 32'h00000013);
    // reset during the wait cycle of a MASK write
    @(negedge clk);
    en = 1'b1; wr = 1'b1; addr = 2'd1; data_in = 32'h0000FFFF;
    #2 reset = 1'b1;
    @(negedge clk);
    en = 1'b0;
    #1;
    chk("mid_wt", 32'(wt), 0);
    chk("mid_irq", 32'(irq), 0);
    chk("mid_dout", data_out, 0);
    @(negedge clk);
    reset = 1'b0;
    acc(0, 0, 2'd1, 0, q);
    chk("mid_mask", q, 0);
    // five-source instance
    acc(1, 1, 2'd1, 32'hFFFFFFFF, q);
    acc(1, 0, 2'd1, 0, q);
    chk("n5_mask", q, 32'h0000001F);
    acc(1, 1, 2'd2, 32'h00000001, q);
    repeat (2) @(negedge clk);
    src5 = 5'h01;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      chk("n5_lat", 32'(irq5[0]), 32'(k == LAT));
    end
    chk("n5_any", 32'(irq_any5), 1);
    acc(1, 0, 2'd3, 0, q);
    chk("n5_vec", q, 32'h80000000);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
